output_acc: RTL and testbench

OUTPUT_ACC -- requirements
Module: output_acc

---
 rtl/output_acc_if.sv | 46 ++++
 rtl/output_acc.sv | 139 +++++++++++++
 tb/tb_output_acc.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_acc_if.sv
// Handshake bundle between the systolic column, output_acc and the unified buffer.
// master drives the column-side controls and ready; slave is the accumulator.
interface output_acc_if;
    logic               output_acc_valid_in;
    logic signed [15:0] output_acc_data_in;
    logic               output_acc_accumulate_in;
    logic               output_acc_rewind_in;
    logic               output_acc_drain_in;
    logic               output_acc_ready_in;
    logic               output_acc_valid_out;
    logic signed [15:0] output_acc_data_out;
    logic               output_acc_full_out;
    logic               output_acc_busy_out;
    logic               output_acc_drop_out;
    logic               output_acc_sat_out;

    modport master (
        output output_acc_valid_in,
        output output_acc_data_in,
        output output_acc_accumulate_in,
        output output_acc_rewind_in,
        output output_acc_drain_in,
        output output_acc_ready_in,
        input  output_acc_valid_out,
        input  output_acc_data_out,
        input  output_acc_full_out,
        input  output_acc_busy_out,
        input  output_acc_drop_out,
        input  output_acc_sat_out
    );

    modport slave (
        input  output_acc_valid_in,
        input  output_acc_data_in,
        input  output_acc_accumulate_in,
        input  output_acc_rewind_in,
        input  output_acc_drain_in,
        input  output_acc_ready_in,
        output output_acc_valid_out,
        output output_acc_data_out,
        output output_acc_full_out,
        output output_acc_busy_out,
        output output_acc_drop_out,
        output output_acc_sat_out
    );
endinterface

// File: rtl/output_acc.sv
// Per-column result accumulator: buffers/accumulates column results, then drains them in order.
// Define OUTPUT_ACC_SAT_EN to saturate accumulates (and flag sat_out); otherwise they wrap.
module output_acc #(
    parameter int unsigned OUTPUT_ACC_DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    output_acc_if.slave bus
);
    localparam int unsigned PtrW = $clog2(OUTPUT_ACC_DEPTH + 1);
    localparam int unsigned IdxW = (OUTPUT_ACC_DEPTH > 1) ? $clog2(OUTPUT_ACC_DEPTH) : 1;
    localparam logic [PtrW-1:0] DepthP = PtrW'(OUTPUT_ACC_DEPTH);

    typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

    state_e             state_q;
    logic signed [15:0] entry_q [OUTPUT_ACC_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q;
    logic [PtrW-1:0]    rd_ptr_q;
    logic [PtrW-1:0]    count_q;
    logic               drop_q;

    logic               full;
    logic               accept;
    logic               drop_evt;
    logic               last_xfer;
    logic [PtrW-1:0]    wr_idx;
    logic [PtrW-1:0]    wr_next;
    logic signed [15:0] old_val;
    logic signed [15:0] wr_val;

    always_comb begin
        full      = (wr_ptr_q == DepthP);
        // Rewind redirects a same-cycle write to index 0, so it is accepted even when full.
        accept    = bus.output_acc_valid_in && (state_q != StDrain) &&
                    (bus.output_acc_rewind_in || !full);
        drop_evt  = bus.output_acc_valid_in && !accept;
        wr_idx    = bus.output_acc_rewind_in ? '0 : wr_ptr_q;
        wr_next   = wr_idx + PtrW'(1);
        old_val   = entry_q[wr_idx[IdxW-1:0]];
        last_xfer = (rd_ptr_q == count_q - PtrW'(1));
    end

`ifdef OUTPUT_ACC_SAT_EN
    logic [16:0] sum;
    logic        sat_evt;
    logic        sat_q;

    always_comb begin
        sum     = {old_val[15], old_val} + {bus.output_acc_data_in[15], bus.output_acc_data_in};
        sat_evt = 1'b0;
        wr_val  = bus.output_acc_data_in;
        if (bus.output_acc_accumulate_in) begin
            if (sum[16] != sum[15]) begin
                sat_evt = 1'b1;
                wr_val  = sum[16] ? 16'sh8000 : 16'sh7FFF;
            end else begin
                wr_val = sum[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (accept && sat_evt) begin
            sat_q <= 1'b1;
        end
    end

    assign bus.output_acc_sat_out = sat_q;
`else
    always_comb begin
        wr_val = bus.output_acc_accumulate_in ? old_val + bus.output_acc_data_in
                                              : bus.output_acc_data_in;
    end

    assign bus.output_acc_sat_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
            for (int unsigned i = 0; i < OUTPUT_ACC_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            if (drop_evt) begin
                drop_q <= 1'b1;
            end
            case (state_q)
                StIdle, StFill: begin
                    if (accept) begin
                        entry_q[wr_idx[IdxW-1:0]] <= wr_val;
                        wr_ptr_q                  <= wr_next;
                        if (wr_next > count_q) begin
                            count_q <= wr_next;
                        end
                        if (state_q == StIdle) begin
                            state_q <= StFill;
                        end
                    end else if (bus.output_acc_rewind_in) begin
                        wr_ptr_q <= '0;
                    end
                    if (state_q == StFill && bus.output_acc_drain_in) begin
                        state_q  <= StDrain;
                        rd_ptr_q <= '0;
                    end
                end
                StDrain: begin
                    if (bus.output_acc_ready_in) begin
                        if (last_xfer) begin
                            state_q  <= StIdle;
                            wr_ptr_q <= '0;
                            rd_ptr_q <= '0;
                            count_q  <= '0;
                            for (int unsigned i = 0; i < OUTPUT_ACC_DEPTH; i++) begin
                                entry_q[i] <= '0;
                            end
                        end else begin
                            rd_ptr_q <= rd_ptr_q + PtrW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.output_acc_valid_out = (state_q == StDrain);
    assign bus.output_acc_busy_out  = (state_q == StDrain);
    assign bus.output_acc_data_out  = (state_q == StDrain) ? entry_q[rd_ptr_q[IdxW-1:0]] : '0;
    assign bus.output_acc_full_out  = full;
    assign bus.output_acc_drop_out  = drop_q;
endmodule

// File: tb/tb_output_acc.sv
// Scoreboard bench for output_acc: expected drain values are queued when a drain is
// requested and checked as each transfer is observed.
module tb_output_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;

    output_acc_if bus ();

    output_acc #(.OUTPUT_ACC_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic signed [15:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int n_xfer = 0;

    // {valid, busy, full, drop, sat, data}
    function automatic logic [20:0] outs();
        return {bus.output_acc_valid_out, bus.output_acc_busy_out, bus.output_acc_full_out,
                bus.output_acc_drop_out, bus.output_acc_sat_out, bus.output_acc_data_out};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.output_acc_valid_out && bus.output_acc_ready_in) begin
            logic signed [15:0] want;
            n_xfer++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL xfer_unexpected: got data=%h, none expected", bus.output_acc_data_out);
            end else begin
                want = exp_q.pop_front();
                if (bus.output_acc_data_out !== want) begin
                    n_fail++;
                    $display("FAIL xfer_data: got %h want %h", bus.output_acc_data_out, want);
                end
            end
        end
    end

    task automatic do_write(input logic [15:0] d, input logic acc, input logic rew);
        bus.output_acc_valid_in      = 1'b1;
        bus.output_acc_data_in       = d;
        bus.output_acc_accumulate_in = acc;
        bus.output_acc_rewind_in     = rew;
        @(posedge clk); #1;
        bus.output_acc_valid_in      = 1'b0;
        bus.output_acc_accumulate_in = 1'b0;
        bus.output_acc_rewind_in     = 1'b0;
    endtask

    task automatic pulse_rewind();
        bus.output_acc_rewind_in = 1'b1;
        @(posedge clk); #1;
        bus.output_acc_rewind_in = 1'b0;
    endtask

    task automatic start_drain();
        bus.output_acc_drain_in = 1'b1;
        @(posedge clk); #1;
        bus.output_acc_drain_in = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() == 0 && bus.output_acc_valid_out === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) exp_q.delete();
    endtask

    task automatic test_reset();
        bus.output_acc_valid_in      = 1'b0;
        bus.output_acc_data_in       = '0;
        bus.output_acc_accumulate_in = 1'b0;
        bus.output_acc_rewind_in     = 1'b0;
        bus.output_acc_drain_in      = 1'b0;
        bus.output_acc_ready_in      = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (outs() !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 000000", outs());
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_overwrite();
        bit ok;
        bus.output_acc_ready_in = 1'b1;
        do_write(16'h0100, 1'b0, 1'b0);
        do_write(16'h0200, 1'b0, 1'b0);
        do_write(16'h0300, 1'b0, 1'b0);
        do_write(16'h0400, 1'b0, 1'b0);
        n_cmp++;
        if (bus.output_acc_full_out !== 1'b1) begin
            n_fail++;
            $display("FAIL overwrite_full: got %b want 1", bus.output_acc_full_out);
        end
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0200);
        exp_q.push_back(16'h0300);
        exp_q.push_back(16'h0400);
        start_drain();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.output_acc_valid_out !== 1'b1) begin
                n_fail++;
                $display("FAIL overwrite_valid_cycle%0d: got %b want 1", i, bus.output_acc_valid_out);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++;
        if (outs() !== 21'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL overwrite_idle_after: got outs=%h left=%0d want 000000/0",
                     outs(), exp_q.size());
            exp_q.delete();
        end
        // Accumulating onto a drained entry proves it was cleared.
        do_write(16'h0007, 1'b1, 1'b0);
        exp_q.push_back(16'h0007);
        start_drain();
        wait_drain(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL overwrite_cleared_drain: got timeout want drain done");
        end
    endtask

    task automatic test_accumulate();
        bit ok;
        for (int i = 0; i < 4; i++) do_write(16'h0010, 1'b0, 1'b0);
        pulse_rewind();
        n_cmp++;
        if (bus.output_acc_full_out !== 1'b0) begin
            n_fail++;
            $display("FAIL accumulate_rewind_full: got %b want 0", bus.output_acc_full_out);
        end
        for (int i = 0; i < 4; i++) begin
            do_write(16'h0005, 1'b1, 1'b0);
            exp_q.push_back(16'h0015);
        end
        start_drain();
        wait_drain(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accumulate_drain: got timeout want drain done");
        end
    endtask

    task automatic test_backpressure();
        int rdy[5] = '{0, 0, 1, 0, 1};
        int seen = 0;
        int xfer0;
        logic signed [15:0] want;
        bus.output_acc_ready_in = 1'b0;
        do_write(16'h1111, 1'b0, 1'b0);
        do_write(16'h2222, 1'b0, 1'b0);
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        xfer0 = n_xfer;
        start_drain();
        for (int i = 0; i < 5; i++) begin
            bus.output_acc_ready_in = rdy[i][0];
            @(negedge clk);
            want = (seen == 0) ? 16'h1111 : 16'h2222;
            n_cmp++;
            if (bus.output_acc_valid_out !== 1'b1 || bus.output_acc_data_out !== want) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: got v=%b d=%h want v=1 d=%h",
                         i, bus.output_acc_valid_out, bus.output_acc_data_out, want);
            end
            if (rdy[i] != 0) seen++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++;
        if (bus.output_acc_valid_out !== 1'b0 || (n_xfer - xfer0) != 2) begin
            n_fail++;
            $display("FAIL backpressure_count: got v=%b xfers=%0d want v=0 xfers=2",
                     bus.output_acc_valid_out, n_xfer - xfer0);
        end
        exp_q.delete();
        bus.output_acc_ready_in = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        bit ok;
        logic signed [15:0] want;
        logic               want_sat;
`ifdef OUTPUT_ACC_SAT_EN
        want     = 16'sh7FFF;
        want_sat = 1'b1;
`else
        want     = 16'sh8100;
        want_sat = 1'b0;
`endif
        do_write(16'h7F00, 1'b0, 1'b0);
        do_write(16'h0200, 1'b1, 1'b1);
        n_cmp++;
        if (bus.output_acc_sat_out !== want_sat) begin
            n_fail++;
            $display("FAIL overflow_sat: got %b want %b", bus.output_acc_sat_out, want_sat);
        end
        exp_q.push_back(want);
        start_drain();
        wait_drain(ok);
        n_cmp++;
        if (!ok || bus.output_acc_sat_out !== want_sat) begin
            n_fail++;
            $display("FAIL overflow_drain: got ok=%b sat=%b want ok=1 sat=%b",
                     ok, bus.output_acc_sat_out, want_sat);
        end
    endtask

    task automatic test_drop();
        bit ok;
        do_write(16'h0A0A, 1'b0, 1'b0);
        do_write(16'h0B0B, 1'b0, 1'b0);
        do_write(16'h0C0C, 1'b0, 1'b0);
        do_write(16'h0D0D, 1'b0, 1'b0);
        n_cmp++;
        if (bus.output_acc_drop_out !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_before: got %b want 0", bus.output_acc_drop_out);
        end
        do_write(16'h5555, 1'b0, 1'b0);
        n_cmp++;
        if (bus.output_acc_drop_out !== 1'b1 || bus.output_acc_full_out !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_set: got drop=%b full=%b want 1/1",
                     bus.output_acc_drop_out, bus.output_acc_full_out);
        end
        exp_q.push_back(16'h0A0A);
        exp_q.push_back(16'h0B0B);
        exp_q.push_back(16'h0C0C);
        exp_q.push_back(16'h0D0D);
        start_drain();
        wait_drain(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drop_drain: got timeout want drain done");
        end
    endtask

    task automatic test_reset_mid_drain();
        bit ok;
        for (int i = 1; i <= 4; i++) begin
            do_write(16'(i * 16'h1000), 1'b0, 1'b0);
            exp_q.push_back(16'(i * 16'h1000));
        end
        start_drain();
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        #2;
        n_cmp++;
        if (bus.output_acc_valid_out !== 1'b1 || bus.output_acc_drop_out !== 1'b1) begin
            n_fail++;
            $display("FAIL middrain_active: got v=%b drop=%b want 1/1",
                     bus.output_acc_valid_out, bus.output_acc_drop_out);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (outs() !== 21'd0) begin
            n_fail++;
            $display("FAIL middrain_reset: got %h want 000000", outs());
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        // Drain request with nothing stored must stay idle.
        start_drain();
        @(negedge clk);
        n_cmp++;
        if (outs() !== 21'd0) begin
            n_fail++;
            $display("FAIL idle_drain_noop: got %h want 000000", outs());
        end
        do_write(16'h0003, 1'b1, 1'b0);
        exp_q.push_back(16'h0003);
        start_drain();
        wait_drain(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_cleared_entry: got timeout want drain done");
        end
    endtask

    initial begin
        test_reset();
        test_overwrite();
        test_accumulate();
        test_backpressure();
        test_overflow();
        test_drop();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
